// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU: AND, NOT, ADD, per-lane saturating add.
// Optional macro ALU_PIPE_STATUS_EN adds ovf_clr / ovf_sticky.
module alu_pipe #(
    parameter int WIDTH  = 16,
    parameter int LANE_W = 8,
    localparam int LANES = WIDTH / LANE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [LANES-1:0] ovf
`ifdef ALU_PIPE_STATUS_EN
    ,
    input  logic             ovf_clr,
    output logic [LANES-1:0] ovf_sticky
`endif
);

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_NOT = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SAT = 2'b11;

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [1:0]       r_s1_op;

    logic             r_s2_valid;
    logic [WIDTH-1:0] r_s2_out;
    logic [LANES-1:0] r_s2_ovf;

    logic             w_s2_advance;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_res;
    logic [LANES-1:0] w_ovf;
    logic [LANE_W:0]  w_lane_sum;

    // S2 can take a new entry when empty or draining this cycle; S1 follows it.
    assign w_s2_advance = !r_s2_valid || out_ready;
    assign in_ready     = !r_s1_valid || w_s2_advance;
    assign out_valid    = r_s2_valid;
    assign out          = r_s2_out;
    assign ovf          = r_s2_ovf;

    assign w_sum = r_s1_a + r_s1_b;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        w_res      = '0;
        w_ovf      = '0;
        w_lane_sum = '0;
        case (r_s1_op)
            OP_AND: w_res = r_s1_a & r_s1_b;
            OP_NOT: w_res = ~r_s1_b;
            OP_ADD: begin
                w_res            = w_sum;
                w_ovf[LANES-1]   = (r_s1_a[WIDTH-1] == r_s1_b[WIDTH-1]) &&
                                   (w_sum[WIDTH-1] != r_s1_a[WIDTH-1]);
            end
            OP_SAT: begin
                for (int i = 0; i < LANES; i++) begin
                    // Sign-extend each lane by one bit; disagreeing top bits mean overflow.
                    w_lane_sum = {r_s1_a[i*LANE_W+LANE_W-1], r_s1_a[i*LANE_W +: LANE_W]} +
                                 {r_s1_b[i*LANE_W+LANE_W-1], r_s1_b[i*LANE_W +: LANE_W]};
                    if (w_lane_sum[LANE_W] != w_lane_sum[LANE_W-1]) begin
                        w_ovf[i] = 1'b1;
                        w_res[i*LANE_W +: LANE_W] = w_lane_sum[LANE_W] ?
                            {1'b1, {(LANE_W-1){1'b0}}} : {1'b0, {(LANE_W-1){1'b1}}};
                    end else begin
                        w_res[i*LANE_W +: LANE_W] = w_lane_sum[LANE_W-1:0];
                    end
                end
            end
            default: w_res = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_op    <= OP_AND;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_a  <= a;
                r_s1_b  <= b;
                r_s1_op <= op;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_out   <= '0;
            r_s2_ovf   <= '0;
        end else if (w_s2_advance) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_out <= w_res;
                r_s2_ovf <= w_ovf;
            end
        end
    end

`ifdef ALU_PIPE_STATUS_EN
    logic [LANES-1:0] r_ovf_sticky;
    logic             w_out_xfer;

    assign w_out_xfer = r_s2_valid && out_ready;
    assign ovf_sticky = r_ovf_sticky;

    // Set has priority: a clear in the same cycle as a flagged transfer keeps the flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_sticky <= '0;
        end else begin
            r_ovf_sticky <= (r_ovf_sticky & ~{LANES{ovf_clr}}) |
                            (w_out_xfer ? r_s2_ovf : '0);
        end
    end
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe (WIDTH=16, LANE_W=8).
// Sticky-flag checks are built only when ALU_PIPE_STATUS_EN is defined.
module tb_alu_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out;
    logic [1:0]  ovf;
`ifdef ALU_PIPE_STATUS_EN
    logic        ovf_clr;
    logic [1:0]  ovf_sticky;
`endif

    int n_checks = 0;
    int n_errors = 0;

    alu_pipe #(.WIDTH(16), .LANE_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .ovf       (ovf)
`ifdef ALU_PIPE_STATUS_EN
        ,
        .ovf_clr   (ovf_clr),
        .ovf_sticky(ovf_sticky)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Starts at a negedge; returns at the negedge where the result is first visible.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [15:0] xa,
                         input logic [15:0] xb, input logic [15:0] exp_out,
                         input logic [1:0] exp_ovf);
        in_valid = 1'b1;
        op       = o;
        a        = xa;
        b        = xb;
        check({tag, "_in_ready"}, in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_early_valid"}, out_valid, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_out"}, out, exp_out);
        check({tag, "_ovf"}, ovf, exp_ovf);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        op        = 2'b00;
`ifdef ALU_PIPE_STATUS_EN
        ovf_clr   = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out", out, 16'h0000);
        check("rst_ovf", ovf, 2'b00);
`ifdef ALU_PIPE_STATUS_EN
        check("rst_sticky", ovf_sticky, 2'b00);
`endif
        rst_n = 1'b1;
        check("rst_in_ready", in_ready, 1'b1);

        // First op lands on the first edge after release.
        do_op("and", 2'b00, 16'hF0F0, 16'hFF00, 16'hF000, 2'b00);
        do_op("add_ovf", 2'b10, 16'h7FFF, 16'h0001, 16'h8000, 2'b10);
        do_op("add_wrap", 2'b10, 16'hFFFF, 16'h0001, 16'h0000, 2'b00);
        do_op("sat_clamp", 2'b11, 16'h7F80, 16'h0180, 16'h7F80, 2'b11);
        do_op("sat_plain", 2'b11, 16'h0102, 16'h0203, 16'h0305, 2'b00);
        do_op("not", 2'b01, 16'h1234, 16'h00FF, 16'hFF00, 2'b00);
        do_op("add_neg", 2'b10, 16'h8000, 16'hFFFF, 16'h7FFF, 2'b10);
        @(negedge clk);
        check("bubble_valid", out_valid, 1'b0);

        // Backpressure: three ops offered while the sink stalls for four cycles.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op = 2'b10; a = 16'h0001; b = 16'h0002;
        @(posedge clk);
        @(negedge clk);
        op = 2'b00; a = 16'h00FF; b = 16'h0F0F;
        check("bp_in_ready1", in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        op = 2'b01; a = 16'h0000; b = 16'h1234;
        check("bp_full_in_ready", in_ready, 1'b0);
        check("bp_valid", out_valid, 1'b1);
        check("bp_out0", out, 16'h0003);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_hold_in_ready", in_ready, 1'b0);
            check("bp_hold_out", out, 16'h0003);
            check("bp_hold_valid", out_valid, 1'b1);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_res2_valid", out_valid, 1'b1);
        check("bp_res2", out, 16'h000F);
        @(posedge clk);
        @(negedge clk);
        check("bp_res3_valid", out_valid, 1'b1);
        check("bp_res3", out, 16'hEDCB);
        @(posedge clk);
        @(negedge clk);
        check("bp_drained", out_valid, 1'b0);

        // Asynchronous reset with both stages full.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op = 2'b00; a = 16'hABCD; b = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        op = 2'b01; b = 16'h0000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("pre_rst_valid", out_valid, 1'b1);
        check("pre_rst_in_ready", in_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 1'b0);
        check("async_rst_out", out, 16'h0000);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        check("post_rst_empty", out_valid, 1'b0);
        do_op("post_rst", 2'b11, 16'h0102, 16'h0203, 16'h0305, 2'b00);
        @(negedge clk);
        check("post_rst_no_ghost", out_valid, 1'b0);

`ifdef ALU_PIPE_STATUS_EN
        do_op("st_a", 2'b11, 16'h7F80, 16'h0180, 16'h7F80, 2'b11);
        @(negedge clk);
        check("sticky_set", ovf_sticky, 2'b11);
        do_op("st_b", 2'b11, 16'h8001, 16'h8001, 16'h8002, 2'b10);
        ovf_clr = 1'b1;
        @(negedge clk);
        check("sticky_set_wins", ovf_sticky, 2'b10);
        @(negedge clk);
        ovf_clr = 1'b0;
        check("sticky_cleared", ovf_sticky, 2'b00);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
